// File: rtl/bubble_position_tracker_pkg.sv
// rtl/bubble_position_tracker_pkg.sv - shared types and constants for the bubble position tracker
//
// Purpose:
//   Holds the items shared by the tracker top and its edge-detect helper:
//   - the fetch FSM state encoding
//   - the default minor-loop length and position width
//   - the read address width rule: one page_select bit above the position bits
// Ports: none (package).

package bubble_position_tracker_pkg;

  // Bubble positions per minor loop on the MB14506-driven device.
  localparam int unsigned LOOP_LENGTH_DEFAULT = 2053;

  // Position/page register width. 2^12 = 4096 covers 0..2052.
  localparam int unsigned POS_WIDTH_DEFAULT = 12;

  // Width of one word returned by the page buffer.
  localparam int unsigned DATA_WIDTH_DEFAULT = 1;

  // Fetch FSM: idle until a data-output-clock edge, then hold the request
  // until the page buffer acknowledges it.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_t;

  // The read address is {page_select, position}, so it is one bit wider
  // than the position.
  function automatic int unsigned addr_width(input int unsigned pos_width);
    return pos_width + 1;
  endfunction

endpackage

// File: rtl/bubble_position_tracker_edge_sync.sv
// rtl/bubble_position_tracker_edge_sync.sv - one-stage input register with rising-edge detect
//
// Purpose:
//   Registers one timing-generator output once, so that glitches from the
//   generator's combinational decode never reach the tracker logic. It also
//   flags a rising edge of the registered value.
// Ports:
//   master_clock  in   system clock; all logic on its rising edge
//   reset         in   synchronous, active-high; clears both history stages
//   sig           in   raw timing-generator signal
//   level         out  registered copy of sig (one cycle of latency)
//   rise          out  level is 1 this cycle and was 0 the cycle before

module bubble_position_tracker_edge_sync
  import bubble_position_tracker_pkg::*;
(
  input  logic master_clock,
  input  logic reset,
  input  logic sig,
  output logic level,
  output logic rise
);

  logic sig_q;
  logic sig_prev_q;

  always_ff @(posedge master_clock) begin
    if (reset) begin
      sig_q      <= 1'b0;
      sig_prev_q <= 1'b0;
    end else begin
      sig_q      <= sig;
      sig_prev_q <= sig_q;
    end
  end

  assign level = sig_q;
  assign rise  = sig_q & ~sig_prev_q;

endmodule

// File: rtl/bubble_position_tracker.sv
// rtl/bubble_position_tracker.sv - minor-loop position tracker and page-buffer fetch engine
//
// Purpose:
//   Sits downstream of the MB14506 timing generator model.
//   - Tracks the bubble position within a minor loop.
//   - Latches the bootloop page on position_latch.
//   - Issues one handshaked page-buffer read per data-output-clock edge.
// Ports:
//   master_clock              in   48 MHz system clock
//   reset                     in   synchronous, active-high reset
//   position_change           in   rise = bubble advanced one position
//   position_latch            in   rise = capture current position as page
//   page_select               in   1 = bootloop page space
//   bubble_access             in   high while the coils run
//   bubble_data_output_clock  in   rise = fetch request
//   read_ack                  in   page buffer accepts; read_data valid now
//   read_data                 in   page buffer data
//   current_position          out  tracked position, 0..LOOP_LENGTH-1
//   latched_page              out  position captured at last latch edge
//   page_valid                out  a page has been latched since reset
//   read_request              out  fetch pending
//   read_address              out  {page_select, position}, held during fetch
//   data_out                  out  last fetched word
//   data_valid                out  one-cycle pulse when data_out updates
//   overrun                   out  sticky; trigger arrived during a fetch

module bubble_position_tracker
  import bubble_position_tracker_pkg::*;
#(
  parameter int unsigned LOOP_LENGTH = LOOP_LENGTH_DEFAULT,
  parameter int unsigned POS_WIDTH   = POS_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEFAULT
) (
  input  logic                             master_clock,
  input  logic                             reset,
  input  logic                             position_change,
  input  logic                             position_latch,
  input  logic                             page_select,
  input  logic                             bubble_access,
  input  logic                             bubble_data_output_clock,
  input  logic                             read_ack,
  input  logic [DATA_WIDTH-1:0]            read_data,
  output logic [POS_WIDTH-1:0]             current_position,
  output logic [POS_WIDTH-1:0]             latched_page,
  output logic                             page_valid,
  output logic                             read_request,
  output logic [addr_width(POS_WIDTH)-1:0] read_address,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             data_valid,
  output logic                             overrun
);

  localparam logic [POS_WIDTH-1:0] LAST_POS = POS_WIDTH'(LOOP_LENGTH - 1);

  // Registered timing inputs
  logic pc_level,   pc_rise;
  logic pl_level,   pl_rise;
  logic ps_level,   ps_rise;
  logic ba_level,   ba_rise;
  logic dclk_level, dclk_rise;

  bubble_position_tracker_edge_sync u_sync_position_change (
    .master_clock (master_clock),
    .reset        (reset),
    .sig          (position_change),
    .level        (pc_level),
    .rise         (pc_rise)
  );

  bubble_position_tracker_edge_sync u_sync_position_latch (
    .master_clock (master_clock),
    .reset        (reset),
    .sig          (position_latch),
    .level        (pl_level),
    .rise         (pl_rise)
  );

  bubble_position_tracker_edge_sync u_sync_page_select (
    .master_clock (master_clock),
    .reset        (reset),
    .sig          (page_select),
    .level        (ps_level),
    .rise         (ps_rise)
  );

  bubble_position_tracker_edge_sync u_sync_bubble_access (
    .master_clock (master_clock),
    .reset        (reset),
    .sig          (bubble_access),
    .level        (ba_level),
    .rise         (ba_rise)
  );

  bubble_position_tracker_edge_sync u_sync_data_clock (
    .master_clock (master_clock),
    .reset        (reset),
    .sig          (bubble_data_output_clock),
    .level        (dclk_level),
    .rise         (dclk_rise)
  );

  // Only page_select and bubble_access are used as levels; the other three
  // are used as edges. The leftovers are collected here on purpose.
  logic unused_sync_outputs;
  assign unused_sync_outputs = pc_level ^ pl_level ^ ps_rise ^ ba_rise ^ dclk_level;

  // Position counter

  logic                 advance;
  logic [POS_WIDTH-1:0] pos_q;
  logic [POS_WIDTH-1:0] pos_next;

  // Coil motion only counts while the coils are driven. The position is
  // held, not cleared, across a stop and restart.
  assign advance = pc_rise & ba_level;

  always_comb begin
    pos_next = pos_q;
    if (advance) begin
      if (pos_q == LAST_POS) begin
        pos_next = '0;
      end else begin
        pos_next = pos_q + POS_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge master_clock) begin
    if (reset) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_next;
    end
  end

  assign current_position = pos_q;

  // Page latch

  logic [POS_WIDTH-1:0] page_q;
  logic                 page_valid_q;

  // The latch captures pos_q, which is the value before any increment in
  // the same cycle.
  always_ff @(posedge master_clock) begin
    if (reset) begin
      page_q       <= '0;
      page_valid_q <= 1'b0;
    end else if (pl_rise) begin
      page_q       <= pos_q;
      page_valid_q <= 1'b1;
    end
  end

  assign latched_page = page_q;
  assign page_valid   = page_valid_q;

  // Fetch FSM

  fetch_state_t                     state_q;
  logic                             trigger;
  logic                             req_q;
  logic [addr_width(POS_WIDTH)-1:0] addr_q;
  logic [DATA_WIDTH-1:0]            data_q;
  logic                             data_valid_q;
  logic                             overrun_q;

  assign trigger = dclk_rise & ba_level;

  always_ff @(posedge master_clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      req_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The address uses the position after this cycle's increment, so a
          // data clock that coincides with an advance fetches the new bubble.
          if (trigger) begin
            state_q <= ST_FETCH;
            req_q   <= 1'b1;
            addr_q  <= {ps_level, pos_next};
          end
        end
        ST_FETCH: begin
          // A second trigger only flags the overrun. The pending address is
          // kept, and a drop of bubble_access does not abort the fetch.
          if (trigger) begin
            overrun_q <= 1'b1;
          end
          if (read_ack) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            data_q       <= read_data;
            data_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // The request is gated by reset so that it drops during the reset cycle.
  // The page buffer must never see a request from a fetch that is being
  // cancelled.
  assign read_request = req_q & ~reset;
  assign read_address = addr_q;
  assign data_out     = data_q;
  assign data_valid   = data_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_bubble_position_tracker.sv
// tb/tb_bubble_position_tracker.sv - self-checking bench for bubble_position_tracker

module tb_bubble_position_tracker;

  logic        master_clock = 1'b0;
  logic        reset = 1'b1;
  logic        position_change = 1'b0;
  logic        position_latch = 1'b0;
  logic        page_select = 1'b0;
  logic        bubble_access = 1'b0;
  logic        bubble_data_output_clock = 1'b0;
  logic        read_ack = 1'b0;
  logic [0:0]  read_data = 1'b0;
  logic [11:0] current_position;
  logic [11:0] latched_page;
  logic        page_valid;
  logic        read_request;
  logic [12:0] read_address;
  logic [0:0]  data_out;
  logic        data_valid;
  logic        overrun;

  typedef struct {
    logic [12:0] addr;
    logic        data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  bubble_position_tracker dut (
    .master_clock             (master_clock),
    .reset                    (reset),
    .position_change          (position_change),
    .position_latch           (position_latch),
    .page_select              (page_select),
    .bubble_access            (bubble_access),
    .bubble_data_output_clock (bubble_data_output_clock),
    .read_ack                 (read_ack),
    .read_data                (read_data),
    .current_position         (current_position),
    .latched_page             (latched_page),
    .page_valid               (page_valid),
    .read_request             (read_request),
    .read_address             (read_address),
    .data_out                 (data_out),
    .data_valid               (data_valid),
    .overrun                  (overrun)
  );

  always #10 master_clock = ~master_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge master_clock);
  endtask

  task automatic pulse_pc();
    position_change = 1'b1;
    cyc(2);
    position_change = 1'b0;
    cyc(2);
  endtask

  task automatic pulse_dclk();
    bubble_data_output_clock = 1'b1;
    cyc(2);
    bubble_data_output_clock = 1'b0;
  endtask

  task automatic wait_request();
    int n = 0;
    while (!read_request && n < 20) begin
      cyc(1);
      n++;
    end
    check("request_seen", {31'd0, read_request}, 32'd1);
  endtask

  // Acks the pending fetch and compares the result with the scoreboard head.
  task automatic ack_and_score(input logic d);
    exp_t e;
    int   n = 0;
    read_data = d;
    read_ack  = 1'b1;
    cyc(1);
    read_ack = 1'b0;
    while (!data_valid && n < 5) begin
      cyc(1);
      n++;
    end
    check("data_valid_pulse", {31'd0, data_valid}, 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("data_out", {31'd0, data_out}, {31'd0, e.data});
    end
    check("request_after_ack", {31'd0, read_request}, 32'd0);
    cyc(1);
    check("data_valid_one_cycle", {31'd0, data_valid}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pos"}, {20'd0, current_position}, 32'd0);
    check({tag, "_page"}, {20'd0, latched_page}, 32'd0);
    check({tag, "_page_valid"}, {31'd0, page_valid}, 32'd0);
    check({tag, "_req"}, {31'd0, read_request}, 32'd0);
    check({tag, "_addr"}, {19'd0, read_address}, 32'd0);
    check({tag, "_data"}, {31'd0, data_out}, 32'd0);
    check({tag, "_dv"}, {31'd0, data_valid}, 32'd0);
    check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    exp_t e;

    // Reset state
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check_all_zero("reset");

    // Full loop: counts 1..2052, then wraps to 0 on pulse 2053
    bubble_access = 1'b1;
    cyc(2);
    for (int i = 1; i <= 2053; i++) begin
      pulse_pc();
      check("count", {20'd0, current_position}, i % 2053);
    end

    // Page latch at position 100
    for (int i = 0; i < 100; i++) pulse_pc();
    check("pos_100", {20'd0, current_position}, 32'd100);
    position_latch = 1'b1;
    cyc(2);
    position_latch = 1'b0;
    cyc(2);
    check("latched_100", {20'd0, latched_page}, 32'd100);
    check("page_valid_set", {31'd0, page_valid}, 32'd1);
    pulse_pc();
    check("pos_101", {20'd0, current_position}, 32'd101);
    check("latched_held", {20'd0, latched_page}, 32'd100);

    // Coils stopped: no advance, no fetch
    bubble_access = 1'b0;
    cyc(2);
    for (int i = 0; i < 3; i++) pulse_pc();
    check("pos_frozen", {20'd0, current_position}, 32'd101);
    pulse_dclk();
    cyc(4);
    check("no_fetch_idle", {31'd0, read_request}, 32'd0);

    // Bootloop page fetch at position 5
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("page_valid_cleared", {31'd0, page_valid}, 32'd0);
    bubble_access = 1'b1;
    cyc(2);
    for (int i = 0; i < 5; i++) pulse_pc();
    page_select = 1'b1;
    cyc(2);
    e.addr = 13'h1005;
    e.data = 1'b1;
    sb.push_back(e);
    pulse_dclk();
    wait_request();
    for (int k = 0; k < 10; k++) begin
      check("addr_hold", {19'd0, read_address}, {19'd0, sb[0].addr});
      check("req_hold", {31'd0, read_request}, 32'd1);
      cyc(1);
    end
    ack_and_score(1'b1);

    // Overrun: second trigger while the ack is withheld
    page_select = 1'b0;
    cyc(2);
    e.addr = 13'h0005;
    e.data = 1'b0;
    sb.push_back(e);
    pulse_dclk();
    wait_request();
    check("addr_page0", {19'd0, read_address}, {19'd0, sb[0].addr});
    check("no_overrun_yet", {31'd0, overrun}, 32'd0);
    cyc(2);
    pulse_dclk();
    cyc(2);
    check("overrun_set", {31'd0, overrun}, 32'd1);
    check("addr_kept", {19'd0, read_address}, 32'h0005);
    check("req_kept", {31'd0, read_request}, 32'd1);
    ack_and_score(1'b0);
    check("overrun_sticky", {31'd0, overrun}, 32'd1);
    check("scoreboard_empty", sb.size(), 32'd0);

    // Reset in the middle of a fetch
    position_latch = 1'b1;
    cyc(2);
    position_latch = 1'b0;
    cyc(2);
    pulse_dclk();
    wait_request();
    reset = 1'b1;
    #1;
    check("req_drop_in_reset", {31'd0, read_request}, 32'd0);
    cyc(1);
    check_all_zero("mid_fetch_reset");
    reset = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bubble_position_tracker.md
Name: bubble_position_tracker

Overview:
- Sits directly downstream of the MB14506 timing generator model.
- Turns its position_change, position_latch, page_select, bubble_access and bubble_data_output_clock outputs into a tracked minor-loop bubble position and a latched bootloop page.
- Issues one handshaked read request per data-output-clock edge to the page buffer, and presents the returned data to the bubble data output logic.

Parameters:
LOOP_LENGTH, 2053, bubble positions per minor loop; position wraps at this value.
POS_WIDTH, 12, width of position/page registers; must satisfy 2^POS_WIDTH >= LOOP_LENGTH.
DATA_WIDTH, 1, width of one fetched data word.

Ports:
master_clock  in  1  48 MHz system clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
position_change  in  1  from timing generator; rising edge = bubble advanced one position.
position_latch  in  1  from timing generator; rising edge = capture current position as bootloop page.
page_select  in  1  from timing generator; 1 = bootloop page space.
bubble_access  in  1  from timing generator; high while coils run.
bubble_data_output_clock  in  1  from timing generator; rising edge = fetch request.
read_ack  in  1  page buffer accepts request; read_data valid same cycle.
read_data  in  DATA_WIDTH  page buffer data.
current_position  out  POS_WIDTH  tracked position, 0..LOOP_LENGTH-1.
latched_page  out  POS_WIDTH  position captured at last position_latch edge.
page_valid  out  1  latched_page has been captured since reset.
read_request  out  1  fetch pending.
read_address  out  POS_WIDTH+1  {page_select, position}, stable while read_request high.
data_out  out  DATA_WIDTH  last fetched word.
data_valid  out  1  one-cycle pulse when data_out updates.
overrun  out  1  sticky; a fetch trigger arrived while read_request was still high.

Behaviour:
- Reset clears every output and internal register to 0.
  - This includes the input registers and the edge-detect history.
  - read_request drops in the reset cycle, even mid-fetch.
- Input stage: all five timing inputs are registered once (one master_clock of latency).
  - Rising edges are detected as registered=1 and previous-registered=0.
  - Upstream outputs are combinational decodes and may glitch; only registered values are used.
- Position counter, on a position_change rise with registered bubble_access=1:
  - current_position == LOOP_LENGTH-1 -> 0; otherwise +1.
  - A rise while bubble_access=0 is ignored.
  - current_position holds across coil stop and restart.
- Page latch: on a position_latch rise, latched_page <= current_position (value before any same-cycle increment) and page_valid <= 1.
  - page_valid stays 1 until reset.
- Fetch FSM states: IDLE, FETCH.
  - IDLE -> FETCH on a bubble_data_output_clock rise while bubble_access=1.
    - Captures read_address = {registered page_select, current_position after any same-cycle increment}.
    - read_request = 1 from the next cycle.
  - FETCH: hold read_request and read_address until read_ack=1.
    - On read_ack: data_out <= read_data, data_valid = 1 for one cycle, return to IDLE.
    - read_ack while IDLE is ignored.
  - A trigger while in FETCH sets overrun=1 (sticky until reset) and is otherwise ignored; the pending request keeps its address.
  - bubble_access falling during FETCH does not abort the fetch.
- Nominal spacing: timing generator data clock pulses are 14 x 12 MHz cycles wide, rising edges 60 x 12 MHz cycles apart. The page buffer must ack within 240 master_clock cycles.

Decomposition:
- Shared package: FSM state encoding (IDLE, FETCH), LOOP_LENGTH default constant, address width expression POS_WIDTH+1.
- One natural sub-module: edge_sync. It is a one-stage register plus rising-edge detect, instantiated five times.

Test Plan:
- Reset, then 2053 position_change pulses with bubble_access=1 -> current_position counts 0..2052 and returns to 0 on pulse 2053.
- Position at 100, position_latch rises -> latched_page=100, page_valid=1; a later position_change leaves latched_page at 100.
- page_select=1, position 5, data clock rise, read_ack after 10 cycles with read_data=1 -> read_address=0x1005 held 10 cycles, data_out=1, data_valid high exactly one cycle.
- Second data clock rise while read_ack is withheld -> overrun=1, read_address unchanged; overrun stays 1 after the ack.
- position_change pulses with bubble_access=0 -> current_position unchanged; a data clock rise starts no fetch.
- Assert reset during FETCH -> read_request=0 in that cycle and all outputs=0 in the next.
